mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer that shares the single physical memory port between the instruction-fetch side and the data (load/store) side of the rv32i pipeline. It sits between the two cache/fetch front-ends and the memory interface. It grants one transaction at a time and registers the winning request onto the memory port. It routes `mem_resp`/`mem_rdata` back to the granted requester and watches for a memory that never responds.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status signals of the shared memory port
interface mem_port_arbiter_if;
    // instruction-fetch side
    logic        i_read;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_resp;
    // load/store side
    logic        d_read;
    logic        d_write;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_resp;
    // physical memory port
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        timeout_err;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
               mem_rdata, mem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_addr, mem_wdata, mem_wmask, timeout_err
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, d_wmask,
               mem_rdata, mem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               mem_read, mem_write, mem_addr, mem_wdata, mem_wmask, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin I/D arbiter sharing one memory port, with response watchdog
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_e;
    typedef enum logic {GNT_I, GNT_D} side_e;

    // A limit outside the 16-bit counter range can never be reached, so it behaves as disabled.
    localparam bit          WD_EN  = (TIMEOUT_CYCLES != 0) && (TIMEOUT_CYCLES < 32'h0001_0000);
    localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYCLES);

    state_e      state_q;
    side_e       last_grant_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;
    logic [15:0] wd_cnt_q;
    logic        timeout_err_q;

    logic        i_pend;
    logic        d_pend;
    logic        grant_i_d;
    logic        grant_d_d;
    logic        resp_i;
    logic        resp_d;
    logic [15:0] wd_cnt_d;
    logic        wd_hit_d;

    always_comb begin
        i_pend    = bus.i_read;
        d_pend    = bus.d_read | bus.d_write;
        // On a tie the side that did not win last time gets the port.
        grant_d_d = d_pend && (!i_pend || (last_grant_q == GNT_I));
        grant_i_d = i_pend && !grant_d_d;
        resp_i    = (state_q == SERVE_I) && bus.mem_resp;
        resp_d    = (state_q == SERVE_D) && bus.mem_resp;
        wd_cnt_d  = (wd_cnt_q == 16'hFFFF) ? wd_cnt_q : (wd_cnt_q + 16'd1);
        wd_hit_d  = WD_EN && (state_q != IDLE) && !bus.mem_resp && (wd_cnt_d == WD_LIM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= GNT_I;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            mem_wmask_q   <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d_d) begin
                        state_q      <= SERVE_D;
                        last_grant_q <= GNT_D;
                        mem_addr_q   <= bus.d_addr;
                        wd_cnt_q     <= '0;
                        // A simultaneous read and write request is served as the write.
                        if (bus.d_write) begin
                            mem_read_q  <= 1'b0;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= bus.d_wdata;
                            mem_wmask_q <= bus.d_wmask;
                        end else begin
                            mem_read_q  <= 1'b1;
                            mem_write_q <= 1'b0;
                            mem_wdata_q <= '0;
                            mem_wmask_q <= 4'b1111;
                        end
                    end else if (grant_i_d) begin
                        state_q      <= SERVE_I;
                        last_grant_q <= GNT_I;
                        mem_addr_q   <= bus.i_addr;
                        mem_read_q   <= 1'b1;
                        mem_write_q  <= 1'b0;
                        mem_wdata_q  <= '0;
                        mem_wmask_q  <= 4'b0000;
                        wd_cnt_q     <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (bus.mem_resp) begin
                        state_q     <= IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                    end else begin
                        wd_cnt_q <= wd_cnt_d;
                        if (wd_hit_d) begin
                            timeout_err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mem_read    = mem_read_q;
    assign bus.mem_write   = mem_write_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.mem_wmask   = mem_wmask_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.i_resp      = resp_i;
    assign bus.d_resp      = resp_d;
    assign bus.i_rdata     = resp_i ? bus.mem_rdata : '0;
    assign bus.d_rdata     = resp_d ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - vector, sequence and randomized model checks for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        i_read, d_read, d_write;
        logic [31:0] i_addr, d_addr, d_wdata;
        logic [3:0]  d_wmask;
        logic [31:0] rdata;
        logic        e_rd, e_wr;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wmask;
        logic        e_iresp, e_dresp;
    } vec_t;

    vec_t vecs[5];

    function automatic vec_t mk(input string name, input logic ir, input logic dr, input logic dw,
                                input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                                input logic [3:0] dm, input logic [31:0] rd,
                                input logic erd, input logic ewr, input logic [31:0] ea,
                                input logic [31:0] ewd, input logic [3:0] em,
                                input logic eir, input logic edr);
        vec_t v;
        v.name = name; v.i_read = ir; v.d_read = dr; v.d_write = dw;
        v.i_addr = ia; v.d_addr = da; v.d_wdata = dwd; v.d_wmask = dm; v.rdata = rd;
        v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea; v.e_wdata = ewd; v.e_wmask = em;
        v.e_iresp = eir; v.e_dresp = edr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
        bus.mem_rdata = '0; bus.mem_resp = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic set_dop(input int op);
        bus.d_read  = (op != 1);
        bus.d_write = (op != 0);
    endtask

    // behavioural reference for the randomized phase
    int          m_owner;   // 0 none, 1 instruction, 2 data
    int          m_last;    // 1 instruction, 2 data
    int          m_wait, m_lat, m_elapsed;
    bit          m_err, m_rd, m_wr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;

    initial begin
        int exp_who[9];
        bit prev_ir, prev_dr;
        int win;
        logic strobe;

        clear_inputs();
        vecs[0] = mk("ifetch", 1, 0, 0, 32'h60, 32'h0, 32'h0, 4'h0, 32'h13,
                     1, 0, 32'h60, 32'h0, 4'b0000, 1, 0);
        vecs[1] = mk("dwrite", 0, 0, 1, 32'h0, 32'h100, 32'hDEADBEEF, 4'b0011, 32'h0,
                     0, 1, 32'h100, 32'hDEADBEEF, 4'b0011, 0, 1);
        vecs[2] = mk("dread", 0, 1, 0, 32'h0, 32'h200, 32'hCAFEF00D, 4'b0101, 32'hA5A5_0001,
                     1, 0, 32'h200, 32'h0, 4'b1111, 0, 1);
        vecs[3] = mk("drw_both", 0, 1, 1, 32'h0, 32'h300, 32'h12345678, 4'b1100, 32'h0,
                     0, 1, 32'h300, 32'h12345678, 4'b1100, 0, 1);
        vecs[4] = mk("tie_reset", 1, 1, 0, 32'h80, 32'h400, 32'h0, 4'h0, 32'h9999_0000,
                     1, 0, 32'h400, 32'h0, 4'b1111, 0, 1);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            settle();
            chk({vecs[v].name, ".rst_mem_read"}, bus.mem_read, 0);
            chk({vecs[v].name, ".rst_mem_write"}, bus.mem_write, 0);
            chk({vecs[v].name, ".rst_mem_addr"}, bus.mem_addr, 0);
            chk({vecs[v].name, ".rst_mem_wmask"}, bus.mem_wmask, 0);
            chk({vecs[v].name, ".rst_timeout"}, bus.timeout_err, 0);
            next_cycle();
            bus.i_read = vecs[v].i_read; bus.i_addr = vecs[v].i_addr;
            bus.d_read = vecs[v].d_read; bus.d_write = vecs[v].d_write;
            bus.d_addr = vecs[v].d_addr; bus.d_wdata = vecs[v].d_wdata; bus.d_wmask = vecs[v].d_wmask;
            settle();
            chk({vecs[v].name, ".no_strobe_yet"}, bus.mem_read | bus.mem_write, 0);
            for (int c = 0; c < 4; c++) begin
                next_cycle();
                bus.i_addr = ~vecs[v].i_addr;
                bus.d_addr = ~vecs[v].d_addr;
                bus.d_wdata = ~vecs[v].d_wdata;
                bus.d_wmask = ~vecs[v].d_wmask;
                if (c == 3) begin
                    bus.mem_resp = 1;
                    bus.mem_rdata = vecs[v].rdata;
                end
                settle();
                chk({vecs[v].name, ".mem_read"}, bus.mem_read, vecs[v].e_rd);
                chk({vecs[v].name, ".mem_write"}, bus.mem_write, vecs[v].e_wr);
                chk({vecs[v].name, ".mem_addr"}, bus.mem_addr, vecs[v].e_addr);
                chk({vecs[v].name, ".mem_wdata"}, bus.mem_wdata, vecs[v].e_wdata);
                chk({vecs[v].name, ".mem_wmask"}, bus.mem_wmask, vecs[v].e_wmask);
                chk({vecs[v].name, ".i_resp"}, bus.i_resp, (c == 3) && vecs[v].e_iresp);
                chk({vecs[v].name, ".d_resp"}, bus.d_resp, (c == 3) && vecs[v].e_dresp);
                chk({vecs[v].name, ".i_rdata"}, bus.i_rdata,
                    ((c == 3) && vecs[v].e_iresp) ? vecs[v].rdata : 32'h0);
                chk({vecs[v].name, ".d_rdata"}, bus.d_rdata,
                    ((c == 3) && vecs[v].e_dresp) ? vecs[v].rdata : 32'h0);
            end
            next_cycle();
            clear_inputs();
            settle();
            chk({vecs[v].name, ".strobe_cleared"}, bus.mem_read | bus.mem_write, 0);
            chk({vecs[v].name, ".resp_cleared"}, bus.i_resp | bus.d_resp, 0);
        end

        // both sides requesting continuously, zero-latency memory: D, -, I, -, D, -, I, -
        do_reset();
        exp_who = '{0, 2, 0, 1, 0, 2, 0, 1, 0};
        bus.i_read = 1; bus.i_addr = 32'hA0;
        bus.d_read = 1; bus.d_addr = 32'hB0;
        bus.mem_rdata = 32'h55;
        for (int c = 0; c < 9; c++) begin
            bus.mem_resp = bus.mem_read | bus.mem_write;
            settle();
            chk($sformatf("alt%0d.strobe", c), bus.mem_read | bus.mem_write, exp_who[c] != 0);
            if (exp_who[c] != 0)
                chk($sformatf("alt%0d.addr", c), bus.mem_addr, (exp_who[c] == 1) ? 32'hA0 : 32'hB0);
            chk($sformatf("alt%0d.i_resp", c), bus.i_resp, exp_who[c] == 1);
            chk($sformatf("alt%0d.d_resp", c), bus.d_resp, exp_who[c] == 2);
            next_cycle();
        end

        // watchdog with a silent memory
        do_reset();
        bus.i_read = 1; bus.i_addr = 32'h40;
        next_cycle();
        for (int k = 0; k < 8; k++) begin
            settle();
            chk($sformatf("wd_wait%0d.mem_read", k), bus.mem_read, 1);
            chk($sformatf("wd_wait%0d.timeout", k), bus.timeout_err, 0);
            next_cycle();
        end
        settle();
        chk("wd.timeout_set", bus.timeout_err, 1);
        repeat (3) next_cycle();
        bus.mem_resp = 1; bus.mem_rdata = 32'h77;
        settle();
        chk("wd.late_i_resp", bus.i_resp, 1);
        chk("wd.late_i_rdata", bus.i_rdata, 32'h77);
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
        settle();
        chk("wd.strobe_after", bus.mem_read, 0);
        chk("wd.timeout_sticky", bus.timeout_err, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("wd.timeout_cleared", bus.timeout_err, 0);

        // asynchronous reset in the middle of a data write
        do_reset();
        bus.d_write = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'h0BAD_F00D; bus.d_wmask = 4'hF;
        next_cycle();
        settle();
        chk("arst.mem_write_before", bus.mem_write, 1);
        next_cycle();
        bus.mem_resp = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.mem_write_dropped", bus.mem_write, 0);
        chk("arst.no_d_resp", bus.d_resp, 0);
        clear_inputs();
        next_cycle();
        rst_n = 1'b1;
        bus.i_read = 1; bus.i_addr = 32'hC0;
        bus.d_read = 1; bus.d_addr = 32'hD0;
        next_cycle();
        settle();
        chk("arst.tie_strobe", bus.mem_read, 1);
        chk("arst.tie_grants_d", bus.mem_addr, 32'hD0);
        next_cycle();
        clear_inputs();
        bus.mem_resp = 1;
        next_cycle();

        // randomized traffic against the reference
        do_reset();
        m_owner = 0; m_last = 1; m_err = 0; m_wait = 0; m_lat = 0; m_elapsed = 0;
        prev_ir = 0; prev_dr = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!bus.i_read) begin
                if ($urandom_range(2) == 0) bus.i_read = 1;
                bus.i_addr = $urandom;
            end else if (prev_ir) begin
                if ($urandom_range(1) == 0) bus.i_read = 0;
                bus.i_addr = $urandom;
            end else if (m_owner == 1) begin
                bus.i_addr = $urandom;
            end
            if (!(bus.d_read | bus.d_write)) begin
                if ($urandom_range(2) == 0) set_dop($urandom_range(2));
                bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_wmask = 4'($urandom);
            end else if (prev_dr) begin
                if ($urandom_range(1) == 0) begin
                    bus.d_read = 0; bus.d_write = 0;
                end else begin
                    set_dop($urandom_range(2));
                end
                bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_wmask = 4'($urandom);
            end else if (m_owner == 2) begin
                bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_wmask = 4'($urandom);
            end
            bus.mem_rdata = $urandom;
            bus.mem_resp = (m_owner != 0) ? (m_elapsed == m_lat) : ($urandom_range(7) == 0);
            settle();

            chk("rnd.mem_read", bus.mem_read, (m_owner != 0) && m_rd);
            chk("rnd.mem_write", bus.mem_write, (m_owner != 0) && m_wr);
            if (m_owner != 0) begin
                chk("rnd.mem_addr", bus.mem_addr, m_addr);
                chk("rnd.mem_wdata", bus.mem_wdata, m_wdata);
                chk("rnd.mem_wmask", bus.mem_wmask, m_wmask);
            end
            prev_ir = (m_owner == 1) && bus.mem_resp;
            prev_dr = (m_owner == 2) && bus.mem_resp;
            chk("rnd.i_resp", bus.i_resp, prev_ir);
            chk("rnd.d_resp", bus.d_resp, prev_dr);
            chk("rnd.i_rdata", bus.i_rdata, prev_ir ? bus.mem_rdata : 32'h0);
            chk("rnd.d_rdata", bus.d_rdata, prev_dr ? bus.mem_rdata : 32'h0);
            chk("rnd.timeout", bus.timeout_err, m_err);

            if (m_owner == 0) begin
                if (bus.i_read && (bus.d_read | bus.d_write)) win = (m_last == 1) ? 2 : 1;
                else if (bus.i_read) win = 1;
                else if (bus.d_read | bus.d_write) win = 2;
                else win = 0;
                if (win == 1) begin
                    m_rd = 1; m_wr = 0; m_addr = bus.i_addr; m_wdata = 0; m_wmask = 4'b0000;
                end else if (win == 2) begin
                    m_addr = bus.d_addr;
                    m_wr = bus.d_write; m_rd = !bus.d_write;
                    m_wdata = bus.d_write ? bus.d_wdata : 32'h0;
                    m_wmask = bus.d_write ? bus.d_wmask : 4'b1111;
                end
                if (win != 0) begin
                    m_owner = win; m_last = win; m_wait = 0; m_elapsed = 0;
                    m_lat = $urandom_range(3);
                end
            end else if (bus.mem_resp) begin
                m_owner = 0;
            end else begin
                m_elapsed++;
                m_wait++;
                if (m_wait == 8) m_err = 1;
            end
            next_cycle();
        end

        strobe = bus.mem_read | bus.mem_write;
        if (strobe) chk("rnd.final_owner", 32'(m_owner != 0), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
